// File: rtl/bin_to_bcd_serial_pkg.sv
// Shared constants for the serial binary-to-BCD converter: FSM encoding,
// BCD digit width and the add-3 correction threshold.
package bin_to_bcd_serial_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bin_to_bcd_serial_if.sv
// Start/busy/done handshake bundle between a requester and the BCD converter.
// The master drives the request; the slave returns status and the held result.
import bin_to_bcd_serial_pkg::*;

interface bin_to_bcd_serial_if #(
  parameter int BIN_WIDTH = 10,
  parameter int DIGITS    = 3
);
  logic                          start;
  logic [BIN_WIDTH-1:0]          bin;
  logic                          busy;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
  logic                          overflow;

  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin_to_bcd_serial_digit_adjust.sv
// Combinational double-dabble correction for one BCD digit: adds 3 when >= 5.
// Zero latency; no handshake.
import bin_to_bcd_serial_pkg::*;

module bcd_digit_adjust (
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);
  assign o_digit = (i_digit >= ADD3_THRESH) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial shift-and-add-3 binary-to-BCD converter, saturating to all nines with overflow.
// Latency start->done is BIN_WIDTH+1 cycles; start is ignored (not queued) while busy.
import bin_to_bcd_serial_pkg::*;

module bin_to_bcd_serial #(
  parameter int BIN_WIDTH = 10,
  parameter int DIGITS    = 3
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  bin_to_bcd_serial_if.slave bus
);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [BCD_W-1:0] NINES = {DIGITS{4'd9}};

  state_e               r_state;
  logic [BIN_WIDTH-1:0] r_shift;
  logic [BCD_W-1:0]     r_work;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf_acc;
  logic                 r_busy;
  logic                 r_done;
  logic [BCD_W-1:0]     r_bcd;
  logic                 r_ovf;
  logic [BCD_W-1:0]     w_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_work    <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.bin;
            r_work    <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= CNT_W'(BIN_WIDTH);
            r_busy    <= 1'b1;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The carry leaving the top digit has nowhere to go: the value no longer fits.
          r_work  <= {w_adj[BCD_W-2:0], r_shift[BIN_WIDTH-1]};
          r_shift <= {r_shift[BIN_WIDTH-2:0], 1'b0};
          r_cnt   <= r_cnt - CNT_W'(1);
          if (w_adj[BCD_W-1]) r_ovf_acc <= 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_bcd   <= r_ovf_acc ? NINES : r_work;
          r_ovf   <= r_ovf_acc;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Bench for bin_to_bcd_serial: directed corner cases plus random operands against
// a decimal-arithmetic reference, on a 10-bit and an 8-bit instance.
module tb_bin_to_bcd_serial;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #10 clk = ~clk;

  bin_to_bcd_serial_if #(.BIN_WIDTH(10), .DIGITS(3)) if10 ();
  bin_to_bcd_serial_if #(.BIN_WIDTH(8),  .DIGITS(3)) if8 ();

  bin_to_bcd_serial #(.BIN_WIDTH(10), .DIGITS(3)) u_dut10 (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (if10.slave)
  );

  bin_to_bcd_serial #(.BIN_WIDTH(8), .DIGITS(3)) u_dut8 (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (if8.slave)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, saturating above 10^digits-1.
  function automatic logic [12:0] ref_conv(input int v, input int digits);
    logic [11:0] r;
    int maxv;
    int x;
    r    = '0;
    maxv = 1;
    x    = v;
    for (int i = 0; i < digits; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    if (v > maxv) begin
      for (int i = 0; i < digits; i++) r[i*4 +: 4] = 4'd9;
      return {1'b1, r};
    end
    for (int i = 0; i < digits; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {1'b0, r};
  endfunction

  // {busy, done, overflow, bcd}
  function automatic logic [14:0] rd(input int sel);
    if (sel == 0) return {if10.busy, if10.done, if10.overflow, if10.bcd};
    return {if8.busy, if8.done, if8.overflow, if8.bcd};
  endfunction

  task automatic drive(input int sel, input int v, input logic s);
    if (sel == 0) begin
      if10.start = s;
      if10.bin   = 10'(v);
    end else begin
      if8.start = s;
      if8.bin   = 8'(v);
    end
  endtask

  // Called at a negedge; start is seen on the next rising edge.
  task automatic convert(input int sel, input int v, input string tag);
    logic [14:0] s;
    logic [12:0] exp;
    int  busyn;
    int  lat;
    int  bw;
    bit  seen;
    busyn = 0;
    lat   = -1;
    seen  = 1'b0;
    bw    = (sel == 0) ? 10 : 8;
    exp   = ref_conv(v, 3);
    drive(sel, v, 1'b1);
    for (int n = 1; n <= bw + 20 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) drive(sel, int'($urandom), 1'b0);
      s = rd(sel);
      if (s[13]) begin
        seen = 1'b1;
        lat  = n - 1;
        chk_eq({tag, " busy_at_done"}, 32'(s[14]), 32'd0);
        chk_eq({tag, " bcd"}, 32'(s[11:0]), 32'(exp[11:0]));
        chk_eq({tag, " ovf"}, 32'(s[12]), 32'(exp[12]));
      end else if (s[14]) begin
        busyn++;
      end
    end
    chk_eq({tag, " done_seen"}, 32'(seen), 32'd1);
    chk_eq({tag, " latency"}, 32'(lat), 32'(bw + 1));
    chk_eq({tag, " busy_cycles"}, 32'(busyn), 32'(bw + 1));
  endtask

  initial begin
    logic [14:0] s;
    int dones;
    int done_n;

    rst = 1'b1;
    drive(0, 0, 1'b0);
    drive(1, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_eq("reset10", 32'(rd(0)), 32'd0);
    chk_eq("reset8",  32'(rd(1)), 32'd0);

    convert(0, 0, "zero");
    convert(0, 255, "v255");
    @(negedge clk);
    chk_eq("v255 done_pulse", 32'(if10.done), 32'd0);
    convert(0, 999, "v999");
    convert(0, 1000, "v1000");
    convert(0, 1023, "v1023");
    convert(0, 1, "v1_after_ovf");

    // Starts during SHIFT and DONE must be dropped, and bin changes ignored.
    dones  = 0;
    done_n = -1;
    drive(0, 42, 1'b1);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      s = rd(0);
      if (s[13]) begin
        dones++;
        done_n = n;
        chk_eq("ign bcd", 32'(s[11:0]), 32'h042);
        chk_eq("ign busy_at_done", 32'(s[14]), 32'd0);
      end
      if (n == 1)  drive(0, 7, 1'b0);
      if (n == 3)  drive(0, 7, 1'b1);
      if (n == 4)  drive(0, 7, 1'b0);
      if (n == 11) drive(0, 7, 1'b1);
      if (n == 12) drive(0, 7, 1'b0);
    end
    chk_eq("ign dones", 32'(dones), 32'd1);
    chk_eq("ign done_cycle", 32'(done_n), 32'd12);
    convert(0, 7, "after_done");

    // Reset in the middle of a conversion aborts it and clears the held result.
    drive(0, 500, 1'b1);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) drive(0, 500, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_eq("abort state", 32'(rd(0)), 32'd0);
    dones = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (if10.done || if10.busy) dones++;
    end
    chk_eq("abort quiet", 32'(dones), 32'd0);
    convert(0, 123, "post_abort");

    convert(1, 200, "w8_v200");
    convert(1, 255, "w8_v255");
    for (int i = 0; i < 15; i++) convert(1, int'($urandom_range(0, 255)), "w8_rand");
    for (int i = 0; i < 40; i++) convert(0, int'($urandom_range(0, 1023)), "w10_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
